// File: rtl/neuron_update_unit_pkg.sv
// Shared types and saturation limits for the neuron update pipeline.
// Limits are derived per width so every instance saturates consistently.
package neuron_update_unit_pkg;

    typedef enum logic {
        RESET_LOAD = 1'b0,
        RESET_SUB  = 1'b1
    } reset_mode_e;

    function automatic logic [31:0] sat_max(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/neuron_update_unit_sat_adder.sv
// Signed W-bit add/subtract that clamps to the representable range.
module SatAdder
    import neuron_update_unit_pkg::*;
#(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y
);

    localparam logic [31:0] MAX32 = sat_max(W);
    localparam logic [31:0] MIN32 = sat_min(W);

    logic [W:0] ax;
    logic [W:0] bx;
    logic [W:0] sum;

    always_comb begin
        ax  = {a[W-1], a};
        bx  = {b[W-1], b};
        sum = sub ? (ax - bx) : (ax + bx);
        y   = sum[W-1:0];
        // Top two bits disagree only when the result left the W-bit range.
        if (sum[W] != sum[W-1]) begin
            y = sum[W] ? MIN32[W-1:0] : MAX32[W-1:0];
        end
    end

endmodule

// File: rtl/neuron_update_unit.sv
// Two-stage neuron update: S1 applies leak, S2 thresholds and resets.
module neuron_update_unit
    import neuron_update_unit_pkg::*;
#(
    parameter int POTENTIAL_WIDTH = 9,
    parameter int LEAK_WIDTH      = 9,
    parameter int NUM_NEURONS     = 256,
    parameter int NEURON_ID_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [POTENTIAL_WIDTH-1:0] potential,
    input  logic [LEAK_WIDTH-1:0]      leak,
    input  logic [POTENTIAL_WIDTH-1:0] pos_threshold,
    input  logic [POTENTIAL_WIDTH-1:0] neg_threshold,
    input  logic [POTENTIAL_WIDTH-1:0] reset_potential,
    input  logic                       reset_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [POTENTIAL_WIDTH-1:0] out_potential,
    output logic [NEURON_ID_WIDTH-1:0] out_neuron_id,
    output logic                       spike,
    output logic                       tick_done
);

    localparam int PW = POTENTIAL_WIDTH;
    localparam logic [NEURON_ID_WIDTH-1:0] LAST_ID =
        NEURON_ID_WIDTH'(NUM_NEURONS - 1);

    logic                       s1_valid;
    logic [PW-1:0]              s1_leaked;
    logic [PW-1:0]              s1_pos;
    logic [PW-1:0]              s1_neg;
    logic [PW-1:0]              s1_rpot;
    reset_mode_e                s1_mode;
    logic [NEURON_ID_WIDTH-1:0] s1_id;
    logic [NEURON_ID_WIDTH-1:0] cnt;

    logic          s2_open;
    logic          in_fire;
    logic [PW-1:0] leak_ext;
    logic [PW-1:0] leaked;
    logic [PW-1:0] diff;
    logic [PW-1:0] next_pot;
    logic          fire;

    assign s2_open  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_open;
    assign in_fire  = in_valid && in_ready;
    assign leak_ext = PW'($signed(leak));

    SatAdder #(.W(PW)) u_leak_add (
        .a   (potential),
        .b   (leak_ext),
        .sub (1'b0),
        .y   (leaked)
    );

    SatAdder #(.W(PW)) u_sub (
        .a   (s1_leaked),
        .b   (s1_pos),
        .sub (1'b1),
        .y   (diff)
    );

    // Firing wins over the floor when the two thresholds overlap.
    always_comb begin
        fire     = $signed(s1_leaked) >= $signed(s1_pos);
        next_pot = s1_leaked;
        if (fire) begin
            next_pot = (s1_mode == RESET_SUB) ? diff : s1_rpot;
        end else if ($signed(s1_leaked) < $signed(s1_neg)) begin
            next_pot = s1_neg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_leaked     <= '0;
            s1_pos        <= '0;
            s1_neg        <= '0;
            s1_rpot       <= '0;
            s1_mode       <= RESET_LOAD;
            s1_id         <= '0;
            cnt           <= '0;
            out_valid     <= 1'b0;
            out_potential <= '0;
            out_neuron_id <= '0;
            spike         <= 1'b0;
            tick_done     <= 1'b0;
        end else begin
            tick_done <= out_valid && out_ready
                         && (out_neuron_id == LAST_ID);
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_fire) begin
                s1_leaked <= leaked;
                s1_pos    <= pos_threshold;
                s1_neg    <= neg_threshold;
                s1_rpot   <= reset_potential;
                s1_mode   <= reset_mode_e'(reset_mode);
                s1_id     <= cnt;
                cnt       <= (cnt == LAST_ID) ? '0 : cnt + 1'b1;
            end
            if (s2_open) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_potential <= next_pot;
                    out_neuron_id <= s1_id;
                    spike         <= fire;
                end
            end
        end
    end

endmodule

// File: tb/tb_neuron_update_unit.sv
// Scoreboard bench for neuron_update_unit with a 4-neuron tick.
module tb_neuron_update_unit;

    typedef struct packed {
        logic [8:0] pot;
        logic       spk;
        logic [7:0] id;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] potential;
    logic [8:0] leak;
    logic [8:0] pos_threshold;
    logic [8:0] neg_threshold;
    logic [8:0] reset_potential;
    logic       reset_mode;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_potential;
    logic [7:0] out_neuron_id;
    logic       spike;
    logic       tick_done;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_id;
    logic [3:0] pat = 4'b1001;

    exp_t mon_e;
    exp_t held;
    logic hold;
    logic exp_tick;

    neuron_update_unit #(
        .POTENTIAL_WIDTH (9),
        .LEAK_WIDTH      (9),
        .NUM_NEURONS     (4),
        .NEURON_ID_WIDTH (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .potential       (potential),
        .leak            (leak),
        .pos_threshold   (pos_threshold),
        .neg_threshold   (neg_threshold),
        .reset_potential (reset_potential),
        .reset_mode      (reset_mode),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_potential   (out_potential),
        .out_neuron_id   (out_neuron_id),
        .spike           (spike),
        .tick_done       (tick_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, req, $time);
        end
    endtask

    task automatic send(input int p, input int l, input int pt,
                        input int nt, input int rp, input logic m,
                        input int ep, input logic es);
        bit done;
        done            = 1'b0;
        potential       = 9'(p);
        leak            = 9'(l);
        pos_threshold   = 9'(pt);
        neg_threshold   = 9'(nt);
        reset_potential = 9'(rp);
        reset_mode      = m;
        in_valid        = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            #1;
            if (in_ready) begin
                q.push_back(exp_t'{pot: 9'(ep), spk: es, id: exp_id});
                exp_id = (exp_id == 8'd3) ? 8'd0 : exp_id + 8'd1;
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold     = 1'b0;
            exp_tick = 1'b0;
        end else begin
            chk("tick_done", int'(tick_done), int'(exp_tick));
            chk("in_ready", int'(in_ready),
                int'(!(q.size() == 2 && !out_ready)));
            if (hold) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_pot", $signed(out_potential),
                    $signed(held.pot));
                chk("hold_spike", int'(spike), int'(held.spk));
                chk("hold_id", int'(out_neuron_id), int'(held.id));
            end
            exp_tick = 1'b0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_output: got id %0d expected none",
                             out_neuron_id);
                end else begin
                    mon_e = q.pop_front();
                    chk("out_pot", $signed(out_potential),
                        $signed(mon_e.pot));
                    chk("out_spike", int'(spike), int'(mon_e.spk));
                    chk("out_id", int'(out_neuron_id), int'(mon_e.id));
                    exp_tick = (mon_e.id == 8'd3);
                end
            end
            hold = out_valid && !out_ready;
            held = exp_t'{pot: out_potential, spk: spike,
                          id: out_neuron_id};
        end
    end

    initial begin
        rst             = 1'b1;
        in_valid        = 1'b0;
        out_ready       = 1'b1;
        potential       = '0;
        leak            = '0;
        pos_threshold   = '0;
        neg_threshold   = '0;
        reset_potential = '0;
        reset_mode      = 1'b0;
        exp_id          = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_pot", int'(out_potential), 0);
        chk("rst_spike", int'(spike), 0);
        chk("rst_id", int'(out_neuron_id), 0);
        chk("rst_tick", int'(tick_done), 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        chk("ready_after_rst", int'(in_ready), 1);
        @(posedge clk);
        #1;

        send(100, -3, 120, -200, 0, 1'b0, 97, 1'b0);
        chk("lat_cycle1_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("lat_cycle2_valid", int'(out_valid), 1);
        chk("lat_pot", $signed(out_potential), 97);
        drain();

        send(130, 0, 120, -200, 0, 1'b1, 10, 1'b1);
        send(130, 0, 120, -200, 0, 1'b0, 0, 1'b1);
        send(130, 0, 120, -200, -5, 1'b0, -5, 1'b1);
        send(250, 20, 100, -200, 0, 1'b1, 155, 1'b1);
        send(-250, -20, 120, -200, 0, 1'b0, -200, 1'b0);
        send(-250, -20, 120, -256, 0, 1'b0, -256, 1'b0);
        send(120, 0, 120, -200, 0, 1'b1, 0, 1'b1);
        send(-50, 0, 120, -50, 0, 1'b0, -50, 1'b0);
        send(200, 0, -100, -200, 0, 1'b1, 255, 1'b1);
        drain();

        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(i * 10, 1, 120, -200, 0, 1'b0,
                         i * 10 + 1, 1'b0);
                end
            end
            begin
                for (int k = 0; k < 16; k++) begin
                    out_ready = pat[k % 4];
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();

        out_ready = 1'b0;
        send(1, 0, 120, -200, 0, 1'b0, 1, 1'b0);
        send(2, 0, 120, -200, 0, 1'b0, 2, 1'b0);
        chk("full_ready", int'(in_ready), 0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_pot", int'(out_potential), 0);
        chk("mid_rst_id", int'(out_neuron_id), 0);
        q.delete();
        exp_id = 8'd0;
        @(negedge clk);
        #2;
        rst       = 1'b0;
        out_ready = 1'b1;
        chk("mid_rst_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        send(5, 0, 120, -200, 0, 1'b0, 5, 1'b0);
        drain();
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
